branch_pc_unit: RTL and testbench
=================================

// Module: branch_pc_unit
// PURPOSE
//  Consumes BrLT/BrEq from the branch comparator plus EX-stage control and resolves every control transfer.
//  Owns the fetch PC register: next-PC select, redirect/flush sequencing, misaligned-target detect, branch stats.
//  Drives BrUn back to the comparator; sits between EX and IF.
// PARAMETERS
//  RESET_PC   32'h0000_0000  if_pc value while/after reset
//  FLUSH_LEN  2              wrong-path bubble cycles after a redirect (1..7)
// PORTS
//  clk        in   1   core clock, rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  stall      in   1   freeze whole unit (PC, flush counter, stats)
//  ex_valid   in   1   EX holds a valid instruction
//  ex_branch  in   1   EX instr is conditional branch
//  ex_jal     in   1   EX instr is JAL
//  ex_jalr    in   1   EX instr is JALR
//  ex_funct3  in   3   branch funct3
//  BrLT       in   1   comparator less-than
//  BrEq       in   1   comparator equal
//  ex_target  in   32  ALU-computed target address
//  BrUn       out  1   comparator unsigned select = ex_funct3[1] (combinational)
//  if_pc      out  32  fetch PC register
//  redirect   out  1   1-cycle pulse: if_pc just loaded a target
//  flush      out  1   high while flush counter != 0; kill IF/ID
//  misalign   out  1   1-cycle pulse: taken target had bit1 set
//  br_cnt     out  16  evaluated conditional branches, saturating
//  taken_cnt  out  16  taken conditional branches, saturating
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   if_pc=RESET_PC; redirect=0; misalign=0; flush_cnt=0 (flush=0); br_cnt=0; taken_cnt=0.
//   Reset mid-flush aborts the flush.
//  Condition from ex_funct3:
//   000 BrEq; 001 !BrEq; 100 BrLT; 101 !BrLT; 110 BrLT; 111 !BrLT; 010/011 never taken.
//  Qualify: act = ex_valid & !stall & !flush. EX contents while flush=1 are wrong-path: ignored, not counted.
//  take = act & (ex_jal | ex_jalr | (ex_branch & cond)).
//  tgt = ex_jalr ? {ex_target[31:1],1'b0} : ex_target.
//  Misaligned: bad = take & tgt[1].
//  Next-state on rising clk, priority order:
//   1. stall=1        -> all registers hold; redirect, misalign <= 0.
//   2. take & !bad    -> if_pc<=tgt; redirect<=1; flush_cnt<=FLUSH_LEN.
//   3. take & bad     -> misalign<=1; if_pc<=if_pc+4; no redirect, no flush.
//   4. otherwise      -> if_pc<=if_pc+4; flush_cnt decrements if nonzero.
//  Latency:
//   decision is combinational in EX; if_pc/redirect/flush update on the next edge.
//   flush is high exactly FLUSH_LEN unstalled cycles.
//  Flush state machine:
//   IDLE (cnt=0) -> FLUSH on a redirect.
//   FLUSH -> IDLE when cnt reaches 0.
//   A redirect is impossible during FLUSH (act=0).
//  Stats:
//   br_cnt++ on act & ex_branch; taken_cnt++ on take & ex_branch.
//   Both saturate at 16'hFFFF, no wrap.
//  Arithmetic: if_pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
//  Simultaneous ex_jal/ex_jalr/ex_branch: any set is a transfer; jalr governs the bit-0 clear.
// TESTING
//  1. Reset, RESET_PC=0, release, idle -> if_pc 0,4,8,C; flush=0, counters 0.
//  2. if_pc=0x10, BEQ funct3=000, BrEq=1, target 0x100 -> BrUn=0.
//     Next edge: if_pc=0x100, redirect 1 cycle, flush 2 cycles, br_cnt=1, taken_cnt=1.
//  3. BGEU funct3=111, BrLT=1 -> BrUn=1, not taken, if_pc+4, br_cnt++, taken_cnt unchanged.
//  4. JALR target 0x201 -> if_pc=0x200.
//     JAL target 0x106 -> misalign pulse, if_pc+4, no flush.
//  5. Redirect, then stall=1 for 3 cycles mid-flush -> flush counter and if_pc frozen.
//     A branch during flush is ignored and uncounted.
//     rst_n low mid-flush -> flush=0 immediately.
//  6. 65540 taken branches -> taken_cnt=br_cnt=16'hFFFF.
//     PC at 32'hFFFF_FFFC, no transfer -> if_pc=0.

Source files
------------

// File: rtl/branch_pc_unit.sv
// Fetch PC owner: resolves branches/jumps from EX, sequences redirect and
// wrong-path flush, flags misaligned targets and keeps saturating branch stats.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned FLUSH_LEN = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic        ex_branch,
  input  logic        ex_jal,
  input  logic        ex_jalr,
  input  logic [2:0]  ex_funct3,
  input  logic        BrLT,
  input  logic        BrEq,
  input  logic [31:0] ex_target,
  output logic        BrUn,
  output logic [31:0] if_pc,
  output logic        redirect,
  output logic        flush,
  output logic        misalign,
  output logic [15:0] br_cnt,
  output logic [15:0] taken_cnt
);

  typedef enum logic {S_IDLE, S_FLUSH} flush_state_e;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_LEN);

  flush_state_e r_state;
  logic [2:0]   r_flush_cnt;
  logic [31:0]  r_pc;
  logic         r_redirect;
  logic         r_misalign;
  logic [15:0]  r_br_cnt;
  logic [15:0]  r_taken_cnt;

  logic         w_cond;
  logic         w_act;
  logic         w_take;
  logic         w_bad;
  logic [31:0]  w_tgt;

  always_comb begin
    w_cond = 1'b0;
    case (ex_funct3)
      3'b000:         w_cond = BrEq;
      3'b001:         w_cond = !BrEq;
      3'b100, 3'b110: w_cond = BrLT;
      3'b101, 3'b111: w_cond = !BrLT;
      default:        w_cond = 1'b0;
    endcase
  end

  // Anything in EX while flushing is wrong-path and must not act or count.
  assign w_act  = ex_valid && !stall && (r_state == S_IDLE);
  assign w_take = w_act && (ex_jal || ex_jalr || (ex_branch && w_cond));
  assign w_tgt  = ex_jalr ? {ex_target[31:1], 1'b0} : ex_target;
  assign w_bad  = w_take && w_tgt[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_flush_cnt <= '0;
      r_pc        <= RESET_PC;
      r_redirect  <= 1'b0;
      r_misalign  <= 1'b0;
      r_br_cnt    <= '0;
      r_taken_cnt <= '0;
    end else if (stall) begin
      r_redirect <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_redirect <= 1'b0;
      r_misalign <= 1'b0;
      if (w_take && !w_bad) begin
        r_pc        <= w_tgt;
        r_redirect  <= 1'b1;
        r_flush_cnt <= FLUSH_INIT;
        r_state     <= S_FLUSH;
      end else begin
        r_pc <= r_pc + 32'd4;
        if (w_bad) begin
          r_misalign <= 1'b1;
        end else if (r_state == S_FLUSH) begin
          r_flush_cnt <= r_flush_cnt - 3'd1;
          if (r_flush_cnt == 3'd1) r_state <= S_IDLE;
        end
      end
      if (w_act && ex_branch && (r_br_cnt != '1))
        r_br_cnt <= r_br_cnt + 16'd1;
      if (w_take && ex_branch && (r_taken_cnt != '1))
        r_taken_cnt <= r_taken_cnt + 16'd1;
    end
  end

  assign BrUn      = ex_funct3[1];
  assign if_pc     = r_pc;
  assign redirect  = r_redirect;
  assign flush     = (r_state == S_FLUSH);
  assign misalign  = r_misalign;
  assign br_cnt    = r_br_cnt;
  assign taken_cnt = r_taken_cnt;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Bench for branch_pc_unit: directed vectors, an arithmetic reference model
// compared every cycle, and literal spot checks that pin the model.
module tb_branch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_branch = 1'b0;
  logic        ex_jal = 1'b0;
  logic        ex_jalr = 1'b0;
  logic [2:0]  ex_funct3 = 3'b000;
  logic        BrLT = 1'b0;
  logic        BrEq = 1'b0;
  logic [31:0] ex_target = 32'h0;
  logic        BrUn;
  logic [31:0] if_pc;
  logic        redirect;
  logic        flush;
  logic        misalign;
  logic [15:0] br_cnt;
  logic [15:0] taken_cnt;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  bit          chk_en = 1'b0;

  branch_pc_unit #(.RESET_PC(32'h0000_0000), .FLUSH_LEN(2)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .ex_valid(ex_valid),
    .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
    .ex_funct3(ex_funct3), .BrLT(BrLT), .BrEq(BrEq), .ex_target(ex_target),
    .BrUn(BrUn), .if_pc(if_pc), .redirect(redirect), .flush(flush),
    .misalign(misalign), .br_cnt(br_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: plain arithmetic on what fetch should see next.
  logic [31:0] m_pc;
  int          m_flush_left;
  logic        m_redirect, m_misalign;
  int          m_br, m_taken;

  function automatic bit branch_taken(input logic [2:0] f3, input logic lt, input logic eq);
    if (f3 == 3'd0) return eq;
    if (f3 == 3'd1) return !eq;
    if (f3 == 3'd4 || f3 == 3'd6) return lt;
    if (f3 == 3'd5 || f3 == 3'd7) return !lt;
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 32'h0; m_flush_left = 0; m_redirect = 0; m_misalign = 0; m_br = 0; m_taken = 0;
    end else begin
      bit act, is_br_taken, take;
      logic [31:0] tgt;
      act = ex_valid && !stall && (m_flush_left == 0);
      is_br_taken = ex_branch && branch_taken(ex_funct3, BrLT, BrEq);
      take = act && (ex_jal || ex_jalr || is_br_taken);
      tgt = ex_target;
      if (ex_jalr) tgt[0] = 1'b0;
      m_redirect = 0;
      m_misalign = 0;
      if (!stall) begin
        if (take && !tgt[1]) begin
          m_pc = tgt; m_redirect = 1; m_flush_left = 2;
        end else begin
          m_pc = m_pc + 32'd4;
          if (take) m_misalign = 1;
          else if (m_flush_left > 0) m_flush_left--;
        end
        if (act && ex_branch && m_br < 65535) m_br++;
        if (take && ex_branch && m_taken < 65535) m_taken++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_if_pc", if_pc, m_pc);
      check("m_redirect", {31'b0, redirect}, {31'b0, m_redirect});
      check("m_flush", {31'b0, flush}, {31'b0, m_flush_left != 0});
      check("m_misalign", {31'b0, misalign}, {31'b0, m_misalign});
      check("m_br_cnt", {16'b0, br_cnt}, 32'(m_br));
      check("m_taken_cnt", {16'b0, taken_cnt}, 32'(m_taken));
      check("m_BrUn", {31'b0, BrUn}, {31'b0, ex_funct3[1]});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_branch = 0; ex_jal = 0; ex_jalr = 0;
    ex_funct3 = 3'b000; BrLT = 0; BrEq = 0; ex_target = 32'h0;
  endtask

  task automatic set_branch(input logic [2:0] f3, input logic lt, input logic eq, input logic [31:0] t);
    ex_valid = 1; ex_branch = 1; ex_funct3 = f3; BrLT = lt; BrEq = eq; ex_target = t;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    clear_ex();
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1;
    rst_n = 1;
    // Idle after reset: 0,4,8,C
    check("rst_pc", if_pc, 32'h0);
    check("rst_flush", {31'b0, flush}, 32'h0);
    check("rst_br", {16'b0, br_cnt}, 32'h0);
    step(); check("idle_pc4", if_pc, 32'h4);
    step(); check("idle_pc8", if_pc, 32'h8);
    step(); check("idle_pcC", if_pc, 32'hC);
    step(); check("idle_pc10", if_pc, 32'h10);

    // BEQ taken to 0x100
    set_branch(3'b000, 0, 1, 32'h100);
    #1 check("beq_brun", {31'b0, BrUn}, 32'h0);
    step(); clear_ex();
    check("beq_pc", if_pc, 32'h100);
    check("beq_redirect", {31'b0, redirect}, 32'h1);
    check("beq_flush", {31'b0, flush}, 32'h1);
    check("beq_br", {16'b0, br_cnt}, 32'h1);
    check("beq_taken", {16'b0, taken_cnt}, 32'h1);
    step();
    check("beq_redir_off", {31'b0, redirect}, 32'h0);
    check("beq_flush2", {31'b0, flush}, 32'h1);
    step();
    check("beq_flush_end", {31'b0, flush}, 32'h0);
    check("beq_pc108", if_pc, 32'h108);

    // BGEU with BrLT=1: not taken
    set_branch(3'b111, 1, 0, 32'h300);
    #1 check("bgeu_brun", {31'b0, BrUn}, 32'h1);
    step(); clear_ex();
    check("bgeu_pc", if_pc, 32'h10C);
    check("bgeu_br", {16'b0, br_cnt}, 32'h2);
    check("bgeu_taken", {16'b0, taken_cnt}, 32'h1);

    // JALR clears bit 0
    ex_valid = 1; ex_jalr = 1; ex_target = 32'h201;
    step(); clear_ex();
    check("jalr_pc", if_pc, 32'h200);
    step(); step();
    // JAL to a target with bit1 set
    ex_valid = 1; ex_jal = 1; ex_target = 32'h106;
    step(); clear_ex();
    check("jal_misalign", {31'b0, misalign}, 32'h1);
    check("jal_pc", if_pc, 32'h20C);
    check("jal_noflush", {31'b0, flush}, 32'h0);
    step();
    check("jal_mis_off", {31'b0, misalign}, 32'h0);

    // BNE taken, then stall mid-flush with a wrong-path branch in EX
    set_branch(3'b001, 0, 0, 32'h400);
    step();
    set_branch(3'b000, 0, 1, 32'h500);
    stall = 1;
    repeat (3) step();
    check("stall_pc", if_pc, 32'h400);
    check("stall_flush", {31'b0, flush}, 32'h1);
    stall = 0;
    step();
    check("wp_pc", if_pc, 32'h404);
    check("wp_br", {16'b0, br_cnt}, 32'h3);
    check("wp_flush", {31'b0, flush}, 32'h1);
    clear_ex();
    #2 rst_n = 0;
    #1 check("rst_mid_flush", {31'b0, flush}, 32'h0);
    check("rst_mid_pc", if_pc, 32'h0);
    step();
    rst_n = 1;

    // Saturation: misaligned taken branches avoid flush so one per cycle
    set_branch(3'b000, 0, 1, 32'h2);
    repeat (65540) step();
    clear_ex();
    check("sat_br", {16'b0, br_cnt}, 32'hFFFF);
    check("sat_taken", {16'b0, taken_cnt}, 32'hFFFF);

    // PC wrap
    ex_valid = 1; ex_jal = 1; ex_target = 32'hFFFF_FFF4;
    step(); clear_ex();
    step(); step();
    check("wrap_pre", if_pc, 32'hFFFF_FFFC);
    step();
    check("wrap_pc", if_pc, 32'h0);

    @(negedge clk);
    #1;
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
